// File: rtl/pipe_stage_elastic.sv
// rtl/pipe_stage_elastic.sv - elastic pipeline stage register with 2-entry skid buffer and flush
// Optional perf counters (stall_cnt_o, flush_cnt_o) built only when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_elastic #(
  parameter int DATA_W = 16,
  parameter int CTRL_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CTRL_W-1:0] out_ctrl_o
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
`endif
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_BUSY  = 2'd1,
    S_FULL  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                out_valid_q, out_valid_d;
  logic                in_ready_q, in_ready_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;

  logic in_fire;
  logic out_fire;

  // Both fire terms come from registered handshake flags, so out_ready_i never reaches in_ready_o.
  assign in_fire  = in_valid_i & in_ready_q;
  assign out_fire = out_valid_q & out_ready_i;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;

    if (flush_i) begin
      state_d = S_EMPTY;
    end else begin
      unique case (state_q)
        S_EMPTY: begin
          if (in_fire) begin
            state_d     = S_BUSY;
            main_data_d = in_data_i;
            main_ctrl_d = in_ctrl_i;
          end
        end
        S_BUSY: begin
          if (in_fire && !out_fire) begin
            state_d     = S_FULL;
            skid_data_d = in_data_i;
            skid_ctrl_d = in_ctrl_i;
          end else if (in_fire && out_fire) begin
            main_data_d = in_data_i;
            main_ctrl_d = in_ctrl_i;
          end else if (out_fire) begin
            state_d = S_EMPTY;
          end
        end
        S_FULL: begin
          if (out_fire) begin
            state_d     = S_BUSY;
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end

    out_valid_d = (state_d != S_EMPTY);
    in_ready_d  = (state_d != S_FULL);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = main_data_q;
  assign out_ctrl_o  = out_valid_q ? main_ctrl_q : '0;

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;
  logic             stall_evt;
  logic             flush_drop_evt;

  // A flush drops something unless the only held entry leaves downstream in the same cycle.
  assign stall_evt      = out_valid_q & ~out_ready_i;
  assign flush_drop_evt = flush_i & ((state_q == S_FULL) | ((state_q == S_BUSY) & ~out_fire));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_evt && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (flush_drop_evt && (flush_cnt_q != {CNT_W{1'b1}})) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule
